// File: rtl/baud_rate_gen.sv
// Baud-rate timer: programmable integer+fractional oversample tick, bit tick every OVS ticks.
// Fractional divisor support is compiled in only when BAUD_RATE_GEN_FRAC_EN is defined.
module baud_rate_gen #(
  parameter int DVSR_W   = 11,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int RST_DVSR = 325
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [DVSR_W-1:0] dvsr_int,
  input  logic [FRAC_W-1:0] dvsr_frac,
  input  logic              sync,
  output logic              tick,
  output logic              bit_tick,
  output logic              upd_pend
);

  localparam int OVS_W = (OVS > 1) ? $clog2(OVS) : 1;

  logic [DVSR_W:0]   cnt;
  logic [DVSR_W:0]   term;
  logic [DVSR_W-1:0] cur_int;
  logic [DVSR_W-1:0] pend_int;
  logic [OVS_W-1:0]  ovs_cnt;
  logic              extend;
  logic              wrap;
  logic              ovs_last;
  logic              apply;

`ifdef BAUD_RATE_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] cur_frac;
  logic [FRAC_W-1:0] pend_frac;
  logic [FRAC_W:0]   acc_sum;
  logic              ext_r;

  assign acc_sum = {1'b0, acc} + {1'b0, cur_frac};
  assign extend  = ext_r;
`else
  logic unused_frac;

  assign unused_frac = ^dvsr_frac;
  assign extend      = 1'b0;
`endif

  assign term     = {1'b0, cur_int} + {{DVSR_W{1'b0}}, extend};
  // >= rather than == so an idle-time reload to a shorter divisor cannot overshoot the terminal count
  assign wrap     = en && !sync && (cnt >= term);
  assign ovs_last = (ovs_cnt == OVS_W'(OVS - 1));
  assign apply    = upd_pend && !sync && (wrap || !en);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      ovs_cnt  <= '0;
      cur_int  <= DVSR_W'(RST_DVSR);
      pend_int <= '0;
      upd_pend <= 1'b0;
      tick     <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      tick     <= wrap;
      bit_tick <= wrap && ovs_last;
      if (sync) begin
        cnt     <= '0;
        ovs_cnt <= '0;
      end else if (en) begin
        if (wrap) begin
          cnt     <= '0;
          ovs_cnt <= ovs_last ? '0 : ovs_cnt + OVS_W'(1);
        end else begin
          cnt <= cnt + (DVSR_W + 1)'(1);
        end
      end
      if (apply) begin
        cur_int  <= pend_int;
        upd_pend <= 1'b0;
      end
      // load comes last so a new request survives the wrap that applies the older one
      if (load) begin
        pend_int <= dvsr_int;
        upd_pend <= 1'b1;
      end
    end
  end

`ifdef BAUD_RATE_GEN_FRAC_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      ext_r     <= 1'b0;
      cur_frac  <= '0;
      pend_frac <= '0;
    end else begin
      if (sync || apply) begin
        acc   <= '0;
        ext_r <= 1'b0;
      end else if (wrap) begin
        {ext_r, acc} <= acc_sum;
      end
      if (apply) cur_frac <= pend_frac;
      if (load)  pend_frac <= dvsr_frac;
    end
  end
`endif

endmodule

// File: tb/tb_baud_rate_gen.sv
// Directed bench for baud_rate_gen: table of divisor settings plus reload, sync, enable and reset sequences.
module tb_baud_rate_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        sync = 1'b0;
  logic [10:0] dvsr_int = '0;
  logic [3:0]  dvsr_frac = '0;
  logic        tick;
  logic        bit_tick;
  logic        upd_pend;

  int n_cmp = 0;
  int n_err = 0;

  baud_rate_gen #(
    .DVSR_W(11),
    .FRAC_W(4),
    .OVS(16),
    .RST_DVSR(325)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .load(load),
    .dvsr_int(dvsr_int),
    .dvsr_frac(dvsr_frac),
    .sync(sync),
    .tick(tick),
    .bit_tick(bit_tick),
    .upd_pend(upd_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dv;
    int fr;
    int first;
    int span;
    int bit_idx;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < max);
    if (!tick) n = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; sync = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Idle load takes effect on the following cycle, leaving cnt at 0 before enabling.
  task automatic load_idle(input int dv, input int fr);
    dvsr_int = 11'(dv); dvsr_frac = 4'(fr); load = 1'b1;
    step();
    check("load_sets_pend", upd_pend, 1);
    load = 1'b0;
    step();
    check("idle_apply_clears_pend", upd_pend, 0);
    en = 1'b1;
  endtask

  initial begin
    int n, k, hits, ntick, t1, t17, bidx, orphan;

    vecs[0] = '{dv: 9, fr: 0, first: 10, span: 160, bit_idx: 16};
`ifdef BAUD_RATE_GEN_FRAC_EN
    vecs[1] = '{dv: 9, fr: 8, first: 10, span: 168, bit_idx: 16};
    vecs[4] = '{dv: 2, fr: 3, first: 3,  span: 51,  bit_idx: 16};
`else
    vecs[1] = '{dv: 9, fr: 8, first: 10, span: 160, bit_idx: 16};
    vecs[4] = '{dv: 2, fr: 3, first: 3,  span: 48,  bit_idx: 16};
`endif
    vecs[2] = '{dv: 0, fr: 0, first: 1,  span: 16,  bit_idx: 16};
    vecs[3] = '{dv: 4, fr: 0, first: 5,  span: 80,  bit_idx: 16};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      check("reset_tick", tick, 0);
      check("reset_bit_tick", bit_tick, 0);
      check("reset_upd_pend", upd_pend, 0);
      load_idle(vecs[i].dv, vecs[i].fr);
      ntick = 0; t1 = -1; t17 = -1; bidx = 0; orphan = 0;
      for (int cyc = 1; cyc <= 600 && ntick < 17; cyc++) begin
        step();
        if (tick) begin
          ntick++;
          if (ntick == 1) t1 = cyc;
          if (ntick == 17) t17 = cyc;
        end
        if (bit_tick) begin
          if (bidx == 0) bidx = ntick;
          if (!tick) orphan++;
        end
      end
      check($sformatf("v%0d_first_tick", i), t1, vecs[i].first);
      check($sformatf("v%0d_span16", i), t17 - t1, vecs[i].span);
      check($sformatf("v%0d_bit_idx", i), bidx, vecs[i].bit_idx);
      check($sformatf("v%0d_bit_without_tick", i), orphan, 0);
    end

    // Reload 9 -> 4 requested with cnt=3; current period finishes first.
    do_reset();
    load_idle(9, 0);
    repeat (3) step();
    dvsr_int = 11'd4; load = 1'b1;
    step();
    load = 1'b0;
    n = 0;
    while (upd_pend && n < 50) begin
      n++;
      step();
    end
    check("reload_pend_cycles", n, 6);
    check("reload_tick_at_apply", tick, 1);
    wait_tick(50, n);
    check("reload_gap1", n, 5);
    wait_tick(50, n);
    check("reload_gap2", n, 5);

    // Two loads while pending: last (1) wins, giving 2-cycle period after the wrap.
    step();
    dvsr_int = 11'd7; load = 1'b1;
    step();
    dvsr_int = 11'd1;
    step();
    load = 1'b0;
    check("overwrite_pend", upd_pend, 1);
    wait_tick(50, n);
    check("overwrite_old_period_end", n, 2);
    check("overwrite_pend_cleared", upd_pend, 0);
    wait_tick(50, n);
    check("overwrite_gap1", n, 2);
    wait_tick(50, n);
    check("overwrite_gap2", n, 2);

    // sync at cnt=6, ovs_cnt=5.
    do_reset();
    load_idle(9, 0);
    repeat (5) wait_tick(50, n);
    repeat (6) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_no_tick", tick, 0);
    wait_tick(50, n);
    check("sync_next_tick", n, 10);
    k = 1;
    while (!bit_tick && k < 40) begin
      wait_tick(50, n);
      k++;
    end
    check("sync_bit_idx", k, 16);

    // sync coinciding with a wrap suppresses the tick.
    repeat (9) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_over_wrap_no_tick", tick, 0);
    wait_tick(50, n);
    check("sync_over_wrap_next", n, 10);

    // en low for 20 cycles at cnt=4 freezes everything.
    do_reset();
    load_idle(9, 0);
    repeat (4) step();
    en = 1'b0;
    hits = 0;
    repeat (20) begin
      step();
      if (tick || bit_tick) hits++;
    end
    check("en_low_no_strobes", hits, 0);
    en = 1'b1;
    wait_tick(50, n);
    check("en_resume_remaining", n, 6);

    // en low forces tick low even with a 1-cycle period.
    do_reset();
    load_idle(0, 0);
    repeat (3) step();
    check("dv0_tick_high", tick, 1);
    en = 1'b0;
    step();
    check("dv0_en_low_tick", tick, 0);

    // Reset mid-period drops pending load and restores the reset divisor.
    do_reset();
    load_idle(9, 0);
    repeat (3) step();
    dvsr_int = 11'd4; load = 1'b1;
    step();
    load = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("midreset_tick", tick, 0);
    check("midreset_bit_tick", bit_tick, 0);
    check("midreset_upd_pend", upd_pend, 0);
    reset = 1'b0;
    wait_tick(400, n);
    check("midreset_rst_dvsr_period", n, 326);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
